nios_ii_debug_ocimem_ctrl: RTL and testbench
============================================

// Module: nios_ii_debug_ocimem_ctrl
// PURPOSE
//  Consumer of the debug-slave sysclk stage: turns take_action_ocimem_a/b and take_no_action_ocimem_a
//  plus jdo into accesses on a 32-bit on-chip debug RAM, returning MonDReg/monitor_ready/monitor_error.
//  The same RAM is shared with the CPU through an Avalon-MM slave; JTAG has priority, CPU is stalled.
//  Single clock domain (system clk).
// PARAMETERS
//  ADDR_W            8   RAM word-address width (depth = 2**ADDR_W words of 32 bits)
//  REQUIRE_DEBUGACK  1   1: JTAG commands rejected unless debugack=1; 0: always accepted
// PORTS
//  clk                      in   1       system clock; all logic on rising edge
//  reset                    in   1       synchronous, active-high
//  jdo                      in   38      JTAG data from sysclk stage, valid in take_* cycle
//  take_action_ocimem_a     in   1       1-cycle pulse: load address, optional read
//  take_no_action_ocimem_a  in   1       1-cycle pulse: read at current address
//  take_action_ocimem_b     in   1       1-cycle pulse: write jdo[34:3] at current address
//  debugack                 in   1       CPU is in debug mode
//  avs_address              in   ADDR_W  CPU word address
//  avs_read / avs_write     in   1       CPU read / write request (held until waitrequest=0)
//  avs_writedata            in   32      CPU write data
//  avs_byteenable           in   4       CPU byte lanes
//  avs_readdata             out  32      CPU read data, valid when avs_read & ~avs_waitrequest
//  avs_waitrequest          out  1       stall CPU
//  MonDReg                  out  32      last JTAG read data
//  monitor_ready            out  1       last accepted JTAG command completed
//  monitor_error            out  1       last JTAG command rejected/dropped
// BEHAVIOUR
//  Reset: MonDReg=0, monitor_ready=0, monitor_error=0, jaddr=0, jtag pending=0, state=IDLE.
//   RAM contents not cleared. Reset mid-access aborts it: no MonDReg update, no CPU completion.
//  Command capture (every cycle): at most one pending JTAG command (type, data).
//   ocimem_a: jaddr <= jdo[17+:ADDR_W] immediately; if jdo[35]=1 queue READ, else no access,
//     monitor_ready<=1 next cycle.
//   no_action_ocimem_a: queue READ. ocimem_b: queue WRITE with data jdo[34:3].
//   Two or more pulses same cycle: priority a > b > no_action; losers dropped, monitor_error<=1.
//   Pulse while a command is pending or in progress: dropped, monitor_error<=1, state unaffected.
//   REQUIRE_DEBUGACK=1 and debugack=0 at pulse: rejected, monitor_error<=1, monitor_ready<=1,
//     no RAM access, jaddr unchanged (incl. ocimem_a load).
//   Accepted command: monitor_ready<=0 and monitor_error<=0 in the cycle after the pulse.
//  FSM states: IDLE, J_RD, C_RD.
//   IDLE, JTAG pending READ: RAM addr=jaddr -> J_RD. Next cycle MonDReg<=RAM q,
//     jaddr<=jaddr+1, monitor_ready<=1, -> IDLE. Latency pulse->ready: 3 cycles.
//   IDLE, JTAG pending WRITE: all 4 bytes written at jaddr, jaddr+1, monitor_ready<=1 next cycle;
//     stay IDLE. Latency pulse->ready: 2 cycles.
//   IDLE, no JTAG pending, avs_write: write with byteenable, avs_waitrequest=0 this cycle.
//   IDLE, no JTAG pending, avs_read: RAM addr=avs_address, waitrequest=1 -> C_RD; in C_RD
//     waitrequest=0, avs_readdata=RAM q, -> IDLE (2 cycles min).
//   avs_read & avs_write together: write wins, read seen next cycle.
//   avs_waitrequest=1 whenever a JTAG command is pending or state=J_RD; CPU op held intact.
//   C_RD is never preempted; pending JTAG command served on return to IDLE.
//   JTAG pulse arriving in same cycle as a CPU request in IDLE: CPU served first (pulse only
//     becomes pending next cycle).
//  jaddr arithmetic: ADDR_W bits, wraps 2**ADDR_W-1 -> 0, no error.
//  monitor_ready/monitor_error are levels, held until next accepted/rejected command.
// TESTING
//  1 reset; debugack=1; ocimem_a jdo[17+:8]=0x10, jdo[35]=0 -> jaddr=0x10, monitor_ready=1 in 2 cycles.
//  2 ocimem_b data 0xDEADBEEF x2, ocimem_a addr 0x10 jdo[35]=1 -> MonDReg=0xDEADBEEF, ready 3 cycles
//    after pulse; no_action_ocimem_a -> MonDReg=second word (jaddr=0x12 after).
//  3 jaddr=0xFF, ocimem_b 0x1 -> write at 0xFF, jaddr=0x00; CPU read 0xFF -> 0x00000001.
//  4 CPU write 0x11223344 be=0101 over 0 -> readback 0x00220044; CPU read held while JTAG
//    READ pending -> waitrequest=1 until JTAG done, then correct data.
//  5 debugack=0, ocimem_b -> monitor_error=1, monitor_ready=1, RAM and jaddr unchanged;
//    a+b same cycle -> a applied, error=1.
//  6 reset asserted in J_RD -> MonDReg=0, ready=0, state IDLE, RAM contents preserved.

Source files
------------

// File: rtl/nios_ii_debug_ocimem_ctrl.sv
// nios_ii_debug_ocimem_ctrl: on-chip debug RAM shared between JTAG commands (priority) and a CPU Avalon-MM slave
module nios_ii_debug_ocimem_ctrl #(
    parameter int ADDR_W           = 8,
    parameter bit REQUIRE_DEBUGACK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              debugack,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);
    typedef enum logic [1:0] {IDLE, J_RD, C_RD} state_t;
    state_t state;
    logic pend, pend_wr, a_done;
    logic [31:0] pend_data;
    logic [ADDR_W-1:0] jaddr;
    logic [31:0] mem [2**ADDR_W];
    logic [31:0] ram_q;
    logic idle, j_go, c_wr, c_rd, any, multi, busy, ok, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0] ram_wd;
    logic [3:0] ram_be;
    logic unused_ok;
    assign unused_ok = &{1'b0, jdo[37:36], jdo[2:0]};
    always_comb begin
        idle     = state == IDLE;
        j_go     = idle & pend;
        c_wr     = idle & ~pend & avs_write;
        c_rd     = idle & ~pend & avs_read & ~avs_write;
        any      = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        multi    = (take_action_ocimem_a & take_action_ocimem_b) |
                   (take_action_ocimem_a & take_no_action_ocimem_a) |
                   (take_action_ocimem_b & take_no_action_ocimem_a);
        busy     = pend | a_done | (state == J_RD);
        ok       = ~REQUIRE_DEBUGACK | debugack;
        ram_we   = ~reset & (j_go ? pend_wr : c_wr);
        ram_addr = j_go ? jaddr : avs_address;
        ram_wd   = j_go ? pend_data : avs_writedata;
        ram_be   = j_go ? 4'hF : avs_byteenable;
    end
    assign avs_waitrequest = pend | (state == J_RD) | (idle & avs_read & ~avs_write);
    assign avs_readdata    = ram_q;
    always_ff @(posedge clk) begin
        ram_q <= mem[ram_addr];
        if (ram_we)
            for (int i = 0; i < 4; i++)
                if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wd[8*i +: 8];
    end
    // Acceptance of a new command only happens when nothing JTAG-side is in flight,
    // so its jaddr/pend updates never collide with the service branch above it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pend          <= 1'b0;
            pend_wr       <= 1'b0;
            pend_data     <= '0;
            a_done        <= 1'b0;
            jaddr         <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            a_done <= 1'b0;
            if (j_go) begin
                pend <= 1'b0;
                if (pend_wr) begin
                    jaddr         <= jaddr + 1'b1;
                    monitor_ready <= 1'b1;
                end else begin
                    state <= J_RD;
                end
            end else if (c_rd) begin
                state <= C_RD;
            end else if (state == J_RD) begin
                MonDReg       <= ram_q;
                jaddr         <= jaddr + 1'b1;
                monitor_ready <= 1'b1;
                state         <= IDLE;
            end else if (state == C_RD) begin
                state <= IDLE;
            end
            if (a_done) monitor_ready <= 1'b1;
            if (any) begin
                if (busy) begin
                    monitor_error <= 1'b1;
                end else if (!ok) begin
                    monitor_error <= 1'b1;
                    monitor_ready <= 1'b1;
                end else begin
                    monitor_ready <= 1'b0;
                    monitor_error <= multi;
                    if (take_action_ocimem_a) begin
                        jaddr   <= jdo[17 +: ADDR_W];
                        pend    <= jdo[35];
                        pend_wr <= 1'b0;
                        a_done  <= ~jdo[35];
                    end else begin
                        pend      <= 1'b1;
                        pend_wr   <= take_action_ocimem_b;
                        pend_data <= jdo[34:3];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_nios_ii_debug_ocimem_ctrl.sv
// tb_nios_ii_debug_ocimem_ctrl: directed vectors and corner sequences for the debug RAM controller
module tb_nios_ii_debug_ocimem_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic [37:0] jdo = '0;
    logic t_a = 1'b0, t_n = 1'b0, t_b = 1'b0, debugack = 1'b1;
    logic [7:0] avs_address = '0;
    logic avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0] avs_byteenable = '0;
    logic [31:0] avs_readdata, MonDReg;
    logic avs_waitrequest, monitor_ready, monitor_error;
    int tests = 0, fails = 0;
    logic [31:0] rd;

    nios_ii_debug_ocimem_ctrl #(.ADDR_W(8), .REQUIRE_DEBUGACK(1'b1)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(t_a), .take_no_action_ocimem_a(t_n), .take_action_ocimem_b(t_b),
        .debugack(debugack), .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable), .avs_readdata(avs_readdata),
        .avs_waitrequest(avs_waitrequest), .MonDReg(MonDReg), .monitor_ready(monitor_ready),
        .monitor_error(monitor_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic a, b, n, dack;
        logic [7:0] addr;
        logic rdf;
        logic [31:0] data;
        logic rdy, err;
        logic [31:0] mon;
        logic [7:0] jad;
    } vec_t;
    vec_t v[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] ja(input logic [7:0] ad, input logic r);
        ja = '0;
        ja[35] = r;
        ja[24:17] = ad;
    endfunction

    function automatic logic [37:0] jd(input logic [31:0] d);
        jd = '0;
        jd[34:3] = d;
    endfunction

    // Called at a negedge; the pulse is sampled at the following posedge.
    task automatic pulse(input logic a, input logic b, input logic n, input logic [37:0] d);
        t_a = a; t_b = b; t_n = n; jdo = d;
        @(negedge clk);
        t_a = 1'b0; t_b = 1'b0; t_n = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] ad, input logic [31:0] d, input logic [3:0] be);
        int k = 0;
        avs_address = ad; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        while (avs_waitrequest && k < 40) begin @(negedge clk); k++; end
        check("cpu_wr_timeout", 32'(k < 40), 1);
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic cpu_wait_read(output logic [31:0] d);
        int k = 0;
        while (avs_waitrequest && k < 40) begin @(negedge clk); k++; end
        check("cpu_rd_timeout", 32'(k < 40), 1);
        d = avs_readdata;
        avs_read = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] ad, output logic [31:0] d);
        avs_address = ad; avs_read = 1'b1;
        @(negedge clk);
        cpu_wait_read(d);
    endtask

    initial begin
        //       a  b  n  dk addr   rd data          rdy err mon           jaddr
        v[0]  = '{1, 0, 0, 1, 8'h10, 0, 32'h0,        1, 0, 32'h0,        8'h10};
        v[1]  = '{0, 1, 0, 1, 8'h00, 0, 32'hDEADBEEF, 1, 0, 32'h0,        8'h11};
        v[2]  = '{0, 1, 0, 1, 8'h00, 0, 32'hCAFEF00D, 1, 0, 32'h0,        8'h12};
        v[3]  = '{1, 0, 0, 1, 8'h10, 1, 32'h0,        1, 0, 32'hDEADBEEF, 8'h11};
        v[4]  = '{0, 0, 1, 1, 8'h00, 0, 32'h0,        1, 0, 32'hCAFEF00D, 8'h12};
        v[5]  = '{1, 0, 0, 1, 8'hFF, 0, 32'h0,        1, 0, 32'hCAFEF00D, 8'hFF};
        v[6]  = '{0, 1, 0, 1, 8'h00, 0, 32'h1,        1, 0, 32'hCAFEF00D, 8'h00};
        v[7]  = '{1, 0, 0, 1, 8'hFF, 1, 32'h0,        1, 0, 32'h1,        8'h00};
        v[8]  = '{0, 1, 0, 0, 8'h00, 0, 32'h55,       1, 1, 32'h1,        8'h00};
        v[9]  = '{1, 0, 0, 0, 8'h20, 1, 32'h0,        1, 1, 32'h1,        8'h00};
        v[10] = '{1, 1, 0, 1, 8'h11, 1, 32'h0,        1, 1, 32'hCAFEF00D, 8'h12};
        v[11] = '{0, 1, 1, 1, 8'h00, 0, 32'h12345678, 1, 1, 32'hCAFEF00D, 8'h13};
        v[12] = '{1, 0, 0, 1, 8'h12, 1, 32'h0,        1, 0, 32'h12345678, 8'h13};

        repeat (3) @(negedge clk);
        check("rst_mon", MonDReg, 0);
        check("rst_ready", 32'(monitor_ready), 0);
        check("rst_error", 32'(monitor_error), 0);
        check("rst_jaddr", 32'(dut.jaddr), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_wait", 32'(avs_waitrequest), 0);

        for (int i = 0; i < 13; i++) begin
            debugack = v[i].dack;
            pulse(v[i].a, v[i].b, v[i].n, v[i].a ? ja(v[i].addr, v[i].rdf) : jd(v[i].data));
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_ready", i), 32'(monitor_ready), 32'(v[i].rdy));
            check($sformatf("v%0d_error", i), 32'(monitor_error), 32'(v[i].err));
            check($sformatf("v%0d_mon", i), MonDReg, v[i].mon);
            check($sformatf("v%0d_jaddr", i), 32'(dut.jaddr), 32'(v[i].jad));
        end
        debugack = 1'b1;

        // Latency: address-only 2 cycles, write 2 cycles, read 3 cycles
        pulse(1, 0, 0, ja(8'h30, 0));
        check("lat_a_c1", 32'(monitor_ready), 0);
        @(negedge clk);
        check("lat_a_c2", 32'(monitor_ready), 1);
        pulse(0, 1, 0, jd(32'hA5A5A5A5));
        check("lat_b_c1", 32'(monitor_ready), 0);
        @(negedge clk);
        check("lat_b_c2", 32'(monitor_ready), 1);
        pulse(1, 0, 0, ja(8'h30, 1));
        check("lat_r_c1", 32'(monitor_ready), 0);
        @(negedge clk);
        check("lat_r_c2", 32'(monitor_ready), 0);
        @(negedge clk);
        check("lat_r_c3", 32'(monitor_ready), 1);
        check("lat_r_mon", MonDReg, 32'hA5A5A5A5);

        // Back-to-back pulse while the first is pending is dropped
        pulse(1, 0, 0, ja(8'h40, 0));
        @(negedge clk);
        pulse(0, 1, 0, jd(32'h1111));
        pulse(0, 1, 0, jd(32'h2222));
        repeat (3) @(negedge clk);
        check("drop_error", 32'(monitor_error), 1);
        check("drop_ready", 32'(monitor_ready), 1);
        pulse(1, 0, 0, ja(8'h40, 1));
        repeat (3) @(negedge clk);
        check("drop_mon", MonDReg, 32'h1111);
        check("drop_jaddr", 32'(dut.jaddr), 32'h41);

        // CPU side: JTAG-written word at 0xFF, byte-enabled write
        cpu_read(8'hFF, rd);
        check("cpu_rd_ff", rd, 32'h1);
        cpu_write(8'h50, 32'h0, 4'hF);
        cpu_write(8'h50, 32'h11223344, 4'b0101);
        cpu_read(8'h50, rd);
        check("cpu_be", rd, 32'h00220044);

        // CPU read stalled behind a pending JTAG read
        pulse(1, 0, 0, ja(8'h10, 0));
        @(negedge clk);
        pulse(0, 0, 1, '0);
        avs_address = 8'h50; avs_read = 1'b1;
        check("hold_wait_pend", 32'(avs_waitrequest), 1);
        @(negedge clk);
        check("hold_wait_jrd", 32'(avs_waitrequest), 1);
        cpu_wait_read(rd);
        check("hold_cpu_data", rd, 32'h00220044);
        check("hold_jtag_mon", MonDReg, 32'hDEADBEEF);
        check("hold_jaddr", 32'(dut.jaddr), 32'h11);
        @(negedge clk);

        // Reset during a JTAG read aborts it but keeps RAM
        pulse(1, 0, 0, ja(8'h10, 1));
        @(negedge clk);
        check("jrd_wait", 32'(avs_waitrequest), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_mon", MonDReg, 0);
        check("rst2_ready", 32'(monitor_ready), 0);
        check("rst2_error", 32'(monitor_error), 0);
        check("rst2_wait", 32'(avs_waitrequest), 0);
        @(negedge clk);
        check("rst2_mon_hold", MonDReg, 0);
        cpu_read(8'h10, rd);
        check("rst2_ram", rd, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
